// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_arbiter_pkg                                                |
// | Purpose  : Shared types and constants for the write-back arbiter: the    |
// |            register address/data types and the queue entry layout.       |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package wb_arbiter_pkg;

  localparam int c_reg_addr_w = 5;
  localparam int c_reg_w      = 32;

  typedef logic [c_reg_addr_w-1:0] RegAddr;
  typedef logic [c_reg_w-1:0]      Register;

  typedef struct packed {
    logic    valid;
    RegAddr  dst;
    Register data;
  } WbEntry;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_arbiter_if                                                 |
// | Purpose  : Bundles the ALU result port, the load-result handshake, the   |
// |            register-file write port and the hazard query of wb_arbiter.  |
// | Modports : master - producer side (ALU, load unit, decode query)         |
// |            slave  - the arbiter                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface wb_arbiter_if #(
  parameter int DEPTH = 4
);
  import wb_arbiter_pkg::*;

  localparam int c_cnt_w = cnt_width(DEPTH);

  logic               alu_valid;
  RegAddr             alu_dst;
  Register            alu_data;
  logic               mem_valid;
  RegAddr             mem_dst;
  Register            mem_data;
  logic               mem_ready;
  logic               write;
  RegAddr             dst;
  Register            rd;
  RegAddr             q_a;
  logic               q_busy;
  logic [c_cnt_w-1:0] count;

  modport master (
    output alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data, q_a,
    input  mem_ready, write, dst, rd, q_busy, count
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data, q_a,
    output mem_ready, write, dst, rd, q_busy, count
  );

endinterface
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_queue                                                      |
// | Purpose  : Load-result queue with per-entry valid bits, squash by        |
// |            destination address and an address-match output.             |
// | Ports    : clk, rst_n     - clock, asynchronous active-low reset         |
// |            enq_*_i        - append an entry at the tail                  |
// |            drain_i        - remove the oldest valid entry (head_o)       |
// |            squash_*_i     - invalidate every entry with that dst         |
// |            q_a_i/match_o  - any valid entry targets q_a_i (non-zero)     |
// |            head_o         - oldest valid entry, count_o - valid entries  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// Entries are kept packed in age order (slot 0 oldest). Squashed and drained
// entries are removed and the survivors close up on the same edge, so holes
// never exist: the tail index equals count and a free slot is guaranteed
// whenever count < DEPTH, even right after a squash in the middle.
module wb_queue
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enq_i,
  input  RegAddr                 enq_dst_i,
  input  Register                enq_data_i,
  input  logic                   drain_i,
  input  logic                   squash_i,
  input  RegAddr                 squash_dst_i,
  input  RegAddr                 q_a_i,
  output WbEntry                 head_o,
  output logic                   match_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int c_cnt_w = cnt_width(DEPTH);

  WbEntry             ent_q [DEPTH];
  WbEntry             ent_d [DEPTH];
  logic [c_cnt_w-1:0] count_q;
  logic [c_cnt_w-1:0] count_d;
  logic [DEPTH-1:0]   w_keep;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_keep[i] = ent_q[i].valid
                  && !(squash_i && (ent_q[i].dst == squash_dst_i))
                  && !(drain_i && (i == 0));
    end
  end

  // Stable compaction of surviving entries followed by the optional append.
  always_comb begin
    int fill;
    fill = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = '0;
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (w_keep[j]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == fill) ent_d[i] = ent_q[j];
        end
        fill = fill + 1;
      end
    end
    if (enq_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == fill) ent_d[i] = '{valid: 1'b1, dst: enq_dst_i, data: enq_data_i};
      end
      fill = fill + 1;
    end
    count_d = c_cnt_w'(fill);
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && (ent_q[i].dst == q_a_i)) match_o = 1'b1;
    end
    if (q_a_i == '0) match_o = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

  assign head_o  = ent_q[0];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_arbiter                                                    |
// | Purpose  : Arbitrates the single register-file write port between an    |
// |            unstallable ALU result and a queue of load results, with      |
// |            WAW squash of queued loads and a hazard query.                |
// | Ports    : clk, rst_n - clock, asynchronous active-low reset             |
// |            bus        - wb_arbiter_if.slave (ALU, load, write, query)    |
// | Params   : DEPTH - load queue entries, power of two in 2..16             |
// | Macro    : WB_LOAD_BYPASS_EN - when defined, a load arriving with the    |
// |            queue empty and the port free is written directly (1 cycle)   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);

  localparam int                 c_cnt_w = cnt_width(DEPTH);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

  logic               w_alu_wr;
  logic               w_mem_acc;
  logic               w_bypass;
  logic               w_enq;
  logic               w_drain;
  logic               w_match;
  WbEntry             w_head;
  logic [c_cnt_w-1:0] w_count;

  logic    write_q, write_d;
  RegAddr  dst_q, dst_d;
  Register rd_q, rd_d;

  // A result for r0 is discarded and therefore does not occupy the port.
  assign w_alu_wr = bus.alu_valid && (bus.alu_dst != '0);

  // Readiness looks only at the registered count: a drain in the same cycle
  // does not open a slot early.
  assign bus.mem_ready = rst_n && (w_count != c_full);
  assign w_mem_acc     = bus.mem_valid && bus.mem_ready;

`ifdef WB_LOAD_BYPASS_EN
  assign w_bypass = w_mem_acc && (bus.mem_dst != '0) && (w_count == '0) && !w_alu_wr;
`else
  assign w_bypass = 1'b0;
`endif

  // r0 loads are accepted (handshake completes) but never stored.
  assign w_enq   = w_mem_acc && (bus.mem_dst != '0) && !w_bypass;
  assign w_drain = !w_alu_wr && !w_bypass && w_head.valid;

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .enq_i        (w_enq),
    .enq_dst_i    (bus.mem_dst),
    .enq_data_i   (bus.mem_data),
    .drain_i      (w_drain),
    .squash_i     (w_alu_wr),
    .squash_dst_i (bus.alu_dst),
    .q_a_i        (bus.q_a),
    .head_o       (w_head),
    .match_o      (w_match),
    .count_o      (w_count)
  );

  always_comb begin
    write_d = 1'b0;
    dst_d   = dst_q;
    rd_d    = rd_q;
    if (w_alu_wr) begin
      write_d = 1'b1;
      dst_d   = bus.alu_dst;
      rd_d    = bus.alu_data;
    end else if (w_bypass) begin
      write_d = 1'b1;
      dst_d   = bus.mem_dst;
      rd_d    = bus.mem_data;
    end else if (w_head.valid) begin
      write_d = 1'b1;
      dst_d   = w_head.dst;
      rd_d    = w_head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      dst_q   <= '0;
      rd_q    <= '0;
    end else begin
      write_q <= write_d;
      dst_q   <= dst_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.write  = write_q;
  assign bus.dst    = dst_q;
  assign bus.rd     = rd_q;
  assign bus.q_busy = w_match;
  assign bus.count  = w_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wb_arbiter                                                 |
// | Purpose  : Scoreboard bench for wb_arbiter. A queue-based reference      |
// |            model predicts every register-file write, the queue count,    |
// |            mem_ready and q_busy; a monitor compares DUT writes against   |
// |            the expectation queue. Honours WB_LOAD_BYPASS_EN.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    RegAddr  dst;
    Register data;
  } ent_t;

  typedef struct {
    int      cyc;
    RegAddr  dst;
    Register data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  ent_t mq[$];     // reference load queue, oldest first
  exp_t exp_q[$];  // expected writes, stamped with the cycle they appear

  wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: checks state-derived outputs, then applies this cycle's
  // inputs to the abstract queue and predicts the write after the next edge.
  initial begin : model
    bit   rdy, busy, alu_wr, acc, byp;
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        rdy  = (mq.size() != DEPTH);
        busy = 1'b0;
        if (bus.q_a != 5'd0) begin
          foreach (mq[i]) if (mq[i].dst == bus.q_a) busy = 1'b1;
        end
        check("mem_ready", 32'(bus.mem_ready), 32'(rdy));
        check("count", 32'(bus.count), 32'(mq.size()));
        check("q_busy", 32'(bus.q_busy), 32'(busy));

        alu_wr = bus.alu_valid && (bus.alu_dst != 5'd0);
        acc    = bus.mem_valid && rdy && (bus.mem_dst != 5'd0);
        byp    = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
        byp = !alu_wr && acc && (mq.size() == 0);
`endif
        if (alu_wr) begin
          exp_q.push_back('{cyc: cyc + 1, dst: bus.alu_dst, data: bus.alu_data});
          for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].dst == bus.alu_dst) mq.delete(i);
          end
        end else if (byp) begin
          exp_q.push_back('{cyc: cyc + 1, dst: bus.mem_dst, data: bus.mem_data});
        end else if (mq.size() > 0) begin
          e = mq.pop_front();
          exp_q.push_back('{cyc: cyc + 1, dst: e.dst, data: e.data});
        end
        if (acc && !byp) begin
          e.dst  = bus.mem_dst;
          e.data = bus.mem_data;
          mq.push_back(e);
        end
      end
    end
  end

  // Monitor: compares the write port every cycle; dst/rd must hold the last
  // written values whenever no write is expected.
  initial begin : monitor
    RegAddr  last_dst;
    Register last_rd;
    exp_t    x;
    bit      exp_now;
    last_dst = '0;
    last_rd  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_dst = '0;
        last_rd  = '0;
      end else begin
        exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("write", 32'(bus.write), 32'(exp_now));
        if (exp_now) begin
          x        = exp_q.pop_front();
          last_dst = x.dst;
          last_rd  = x.data;
        end
        check("dst", 32'(bus.dst), 32'(last_dst));
        check("rd", bus.rd, last_rd);
      end
    end
  end

  task automatic drive(input bit av, input RegAddr ad, input Register adata,
                       input bit mv, input RegAddr md, input Register mdata,
                       input RegAddr qa);
    bus.alu_valid = av;
    bus.alu_dst   = ad;
    bus.alu_data  = adata;
    bus.mem_valid = mv;
    bus.mem_dst   = md;
    bus.mem_data  = mdata;
    bus.q_a       = qa;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input RegAddr qa);
    repeat (n) drive(1'b0, '0, '0, 1'b0, '0, '0, qa);
  endtask

  initial begin
    bus.alu_valid = 1'b0;
    bus.alu_dst   = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_dst   = '0;
    bus.mem_data  = '0;
    bus.q_a       = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_dst", 32'(bus.dst), 32'd0);
    check("rst_rd", bus.rd, 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    rst_n = 1'b1;
    idle(2, '0);

    // Single ALU result, one-cycle latency
    drive(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, '0);
    check("alu_write", 32'(bus.write), 32'd1);
    check("alu_dst", 32'(bus.dst), 32'd5);
    check("alu_rd", bus.rd, 32'h1234);
    idle(2, '0);

    // Four loads while the ALU owns the port, then a refused fifth
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'd9, 32'h900 + i, 1'b1, 5'(i), 32'h100 + i, '0);
    end
    drive(1'b1, 5'd9, 32'h999, 1'b1, 5'd6, 32'h66, '0);
    check("full_count", 32'(bus.count), 32'd4);
    check("full_ready", 32'(bus.mem_ready), 32'd0);
    idle(6, '0);

    // WAW squash of a queued load
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd7, 32'hAA, '0);
    check("pre_squash_count", 32'(bus.count), 32'd1);
    drive(1'b1, 5'd7, 32'hBB, 1'b0, '0, '0, 5'd7);
    check("squash_count", 32'(bus.count), 32'd0);
    check("squash_rd", bus.rd, 32'hBB);
    idle(3, '0);

    // r0 writes are discarded
    repeat (3) drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, '0);
    check("r0_count", 32'(bus.count), 32'd0);
    idle(2, '0);

    // Hazard query
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd3, 32'h33, 5'd3);
    drive(1'b1, 5'd9, 32'h2, 1'b0, '0, '0, 5'd3);
    check("busy_hit", 32'(bus.q_busy), 32'd1);
    drive(1'b1, 5'd9, 32'h3, 1'b0, '0, '0, 5'd0);
    idle(2, 5'd3);
    check("busy_after_drain", 32'(bus.q_busy), 32'd0);

    // Randomized traffic over a small address range to provoke squashes
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));
    end
    idle(8, '0);

    // Reset in the middle of a drain
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'd9, 32'h700 + i, 1'b1, 5'(10 + i), 32'h500 + i, '0);
    end
    check("pre_reset_count", 32'(bus.count), 32'd3);
    idle(1, '0);
    check("pre_reset_write", 32'(bus.write), 32'd1);
    rst_n = 1'b0;
    mq.delete();
    exp_q.delete();
    #1;
    check("mid_rst_write", 32'(bus.write), 32'd0);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_ready", 32'(bus.mem_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5, '0);

    // Single load on an idle port
    drive(1'b0, '0, '0, 1'b1, 5'd12, 32'hC0DE, '0);
`ifdef WB_LOAD_BYPASS_EN
    check("bypass_write", 32'(bus.write), 32'd1);
`else
    check("queued_load_lat", 32'(bus.write), 32'd0);
`endif
    idle(4, '0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, load-result queue entries, power of two, 2..16.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserted when 0.
REQ-004 alu_valid  input  1  ALU result present this cycle; cannot be stalled.
REQ-005 alu_dst  input  5  ALU destination register address (RegAddr).
REQ-006 alu_data  input  32  ALU result (Register).
REQ-007 mem_valid  input  1  load result offered.
REQ-008 mem_dst  input  5  load destination address.
REQ-009 mem_data  input  32  load data.
REQ-010 mem_ready  output  1  load result accepted when mem_valid && mem_ready.
REQ-011 write  output  1  register-file write enable to the decode stage.
REQ-012 dst  output  5  register-file write address.
REQ-013 rd  output  32  register-file write data.
REQ-014 q_a  input  5  hazard query address (decode rs).
REQ-015 q_busy  output  1  high when any valid queue entry targets q_a and q_a != 0.
REQ-016 count  output  $clog2(DEPTH)+1  valid queue entries.

Function
REQ-017 write/dst/rd SHALL be registered; one write per cycle maximum.
REQ-018 Priority: ALU result SHALL win the write port; else oldest valid queue entry drains.
REQ-019 ALU path latency SHALL be exactly 1 cycle: alu_valid at edge N -> write=1, dst=alu_dst, rd=alu_data after edge N+1.
REQ-020 Accepted load SHALL enqueue at queue tail; drain is strictly FIFO among valid entries.
REQ-021 mem_ready SHALL be combinationally !(count==DEPTH), except simultaneous drain does not raise it (no full-pass-through).
REQ-022 Simultaneous enqueue and drain SHALL keep count unchanged; read/write pointers wrap modulo DEPTH.
REQ-023 Writes with destination 0 SHALL be discarded: ALU -> write stays 0; load -> accepted but not enqueued.
REQ-024 WAW squash: when ALU path writes register R, every valid queue entry with dst R SHALL be invalidated same edge; invalidated entries are skipped without consuming a write cycle, and count decrements accordingly.
REQ-025 q_busy SHALL be combinational over valid entries only; a load accepted this cycle is not yet visible.
REQ-026 Empty queue and no ALU result -> write=0, dst and rd hold previous values.
REQ-027 No X propagation: unused outputs driven to defined values at all times.

Reset
REQ-028 On reset assertion, asynchronously: write=0, dst=0, rd=0, count=0, all entries invalid, pointers 0.
REQ-029 mem_ready SHALL be 0 while reset asserted and 1 on the first cycle after deassertion.
REQ-030 Queued loads in flight at reset SHALL be lost; no write after deassertion until new input.

Configuration
REQ-031 Macro WB_LOAD_BYPASS_EN: defined -> load with empty queue and no alu_valid writes directly in 1 cycle (bypasses queue, no enqueue); undefined -> every load passes through the queue, minimum latency 2 cycles.
REQ-032 Squash, ordering and reset behaviour SHALL be identical in both builds.

Structure
REQ-033 RegAddr, Register and a WbEntry struct (valid, dst, data) SHALL live in the shared definitions package.
REQ-034 One sub-module, wb_queue (circular buffer with per-entry valid, squash-by-address, match output), is instantiated once.

Verification
REQ-035 alu_valid=1, alu_dst=5, alu_data=0x1234 -> next cycle write=1, dst=5, rd=0x1234.
REQ-036 Four loads dst=1..4 with alu_valid held 1 (dst=9) -> count=4, mem_ready=0; release ALU -> writes 1,2,3,4 in order on consecutive cycles.
REQ-037 Queue holds load dst=7 data=0xAA; ALU writes dst=7 data=0xBB -> rd=0xBB only, load never written, count 1->0.
REQ-038 Load dst=0 and ALU dst=0 -> write never asserted, count stays 0.
REQ-039 Queue holds dst=3; q_a=3 -> q_busy=1; q_a=0 -> q_busy=0; after drain q_a=3 -> q_busy=0.
REQ-040 Reset asserted mid-drain with count=3 -> write=0, count=0 immediately; after release no writes; WB_LOAD_BYPASS_EN build: single load on idle port written next cycle.
